wb_regfile: RTL

Writeback stage and register file for the parallel CPU core. It consumes the `wr_en`/`sel_datain` control produced by the access-stage decoder and selects the writeback source: ALU result, load data or call link address. It registers the selected value for one cycle, then commits it to an 8 x 16-bit register file. Two combinational read ports bypass the pending writeback entry, so decode sees the newest value.

---
 rtl/wb_regfile.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
//   Writeback stage and register file. A legal writeback request from the
//   access stage is captured into a one-entry writeback register, then
//   committed to the register file on the following edge. Two combinational
//   read ports bypass the pending writeback entry so decode sees the newest
//   value.
//
// Ports
//   clk         : single clock, all state updates on the rising edge
//   reset       : synchronous, active-high
//   stall       : when 1, the incoming writeback request is dropped
//   wr_en       : writeback request
//   sel_datain  : source select (1 ALU, 2 memory, 3/4 link)
//   dst         : destination register (ignored for link writes)
//   alu_data    : ALU result
//   mem_data    : load data
//   link_data   : return address for call/callr
//   ra_addr/rb_addr : read port addresses
//   ra_data/rb_data : read port data (bypassed)
//   wb_valid    : writeback register holds an entry committing next edge
//   wb_addr/wb_data : writeback register contents
//   sel_err     : sticky flag, set on a request with an illegal select
// -----------------------------------------------------------------------------
module wb_regfile #(
  parameter int DATA_W   = 16,
  parameter int NREG     = 8,
  parameter int LINK_REG = 7,
  localparam int AW      = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              wr_en,
  input  logic [2:0]        sel_datain,
  input  logic [AW-1:0]     dst,
  input  logic [DATA_W-1:0] alu_data,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] link_data,
  input  logic [AW-1:0]     ra_addr,
  input  logic [AW-1:0]     rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic              wb_valid,
  output logic [AW-1:0]     wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              sel_err
);

  localparam logic [AW-1:0] LINK_ADDR = AW'(LINK_REG);

  localparam logic [2:0] SEL_ALU   = 3'd1;
  localparam logic [2:0] SEL_MEM   = 3'd2;
  localparam logic [2:0] SEL_CALL  = 3'd3;
  localparam logic [2:0] SEL_CALLR = 3'd4;

  logic              wb_valid_q, wb_valid_d;
  logic [AW-1:0]     wb_addr_q,  wb_addr_d;
  logic [DATA_W-1:0] wb_data_q,  wb_data_d;
  logic              sel_err_q,  sel_err_d;
  logic [DATA_W-1:0] rf_q [NREG];
  logic [DATA_W-1:0] rf_d [NREG];

  logic sel_legal;
  logic req;

  // ---------------------------------------------------------------------------
  // Capture of the writeback request
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_legal  = (sel_datain >= SEL_ALU) && (sel_datain <= SEL_CALLR);
    req        = wr_en && !stall;
    wb_valid_d = 1'b0;
    wb_addr_d  = wb_addr_q;   // address/data hold when nothing is captured
    wb_data_d  = wb_data_q;
    sel_err_d  = sel_err_q;

    if (req) begin
      if (sel_legal) begin
        wb_valid_d = 1'b1;
        case (sel_datain)
          SEL_ALU: begin
            wb_data_d = alu_data;
            wb_addr_d = dst;
          end
          SEL_MEM: begin
            wb_data_d = mem_data;
            wb_addr_d = dst;
          end
          default: begin
            // call / callr: link address always lands in the link register
            wb_data_d = link_data;
            wb_addr_d = LINK_ADDR;
          end
        endcase
      end else begin
        sel_err_d = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Commit: the pending entry writes its register regardless of stall
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_rf_next
      assign rf_d[gi] = (wb_valid_q && (wb_addr_q == AW'(gi))) ? wb_data_q : rf_q[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      sel_err_q  <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      sel_err_q  <= sel_err_d;
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports: the pending entry is newer than the register file contents
  // ---------------------------------------------------------------------------
  always_comb begin
    ra_data = (wb_valid_q && (wb_addr_q == ra_addr)) ? wb_data_q : rf_q[ra_addr];
    rb_data = (wb_valid_q && (wb_addr_q == rb_addr)) ? wb_data_q : rf_q[rb_addr];
  end

  assign wb_valid = wb_valid_q;
  assign wb_addr  = wb_addr_q;
  assign wb_data  = wb_data_q;
  assign sel_err  = sel_err_q;

endmodule
